// File: rtl/btb_assoc_pkg.sv
// rtl/btb_assoc_pkg.sv - shared geometry, entry type and address helpers for btb_assoc
package btb_assoc_pkg;

  localparam int XLEN         = 32;
  localparam int BTB_NUM_SETS = 8;
  localparam int BTB_NUM_WAYS = 2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target_pc;
  } BTB_ASSOC_ENTRY;

  // Tag is held at full width; the top (2 + idx_bits) bits are always zero.
  function automatic logic [XLEN-1:0] pc_tag(input logic [XLEN-1:0] pc, input int idx_bits);
    return pc >> (2 + idx_bits);
  endfunction

endpackage

// File: rtl/btb_way_match.sv
// rtl/btb_way_match.sv - tag compare across one set with lowest-way priority
module btb_way_match
  import btb_assoc_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int WAY_BITS = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0]           valid,
  input  logic [NUM_WAYS-1:0][XLEN-1:0] tags,
  input  logic [XLEN-1:0]               tag,
  output logic                          match,
  output logic [WAY_BITS-1:0]           match_way
);

  // Scan high to low so the lowest matching way is the one left standing.
  always_comb begin
    match     = 1'b0;
    match_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[w] && (tags[w] == tag)) begin
        match     = 1'b1;
        match_way = WAY_BITS'(w);
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative branch target buffer with round-robin victim pointer
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int NUM_SETS = BTB_NUM_SETS,
  parameter int NUM_WAYS = BTB_NUM_WAYS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        write_enable,
  input  logic [XLEN-1:0]             write_source_pc,
  input  logic [XLEN-1:0]             write_dest_pc,
  input  logic                        inval_enable,
  input  logic [XLEN-1:0]             inval_pc,
  input  logic [XLEN-1:0]             query_pc,
  output logic                        hit,
  output logic [XLEN-1:0]             target_pc,
  output logic [$clog2(NUM_WAYS)-1:0] hit_way
);

  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [WAY_BITS-1:0] way_t;

  BTB_ASSOC_ENTRY entries [NUM_SETS][NUM_WAYS];
  way_t           victim  [NUM_SETS];

  idx_t            q_idx, w_idx, i_idx;
  logic [XLEN-1:0] q_tag, w_tag, i_tag;

  assign q_idx = query_pc[2 +: IDX_BITS];
  assign w_idx = write_source_pc[2 +: IDX_BITS];
  assign i_idx = inval_pc[2 +: IDX_BITS];
  assign q_tag = pc_tag(query_pc, IDX_BITS);
  assign w_tag = pc_tag(write_source_pc, IDX_BITS);
  assign i_tag = pc_tag(inval_pc, IDX_BITS);

  logic [NUM_WAYS-1:0]           q_valid, w_valid, i_valid;
  logic [NUM_WAYS-1:0][XLEN-1:0] q_tags, w_tags, i_tags;

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      q_valid[w] = entries[q_idx][w].valid;
      q_tags[w]  = entries[q_idx][w].tag;
      w_valid[w] = entries[w_idx][w].valid;
      w_tags[w]  = entries[w_idx][w].tag;
      i_valid[w] = entries[i_idx][w].valid;
      i_tags[w]  = entries[i_idx][w].tag;
    end
  end

  logic q_match, w_match, i_match;
  way_t q_way, w_way, i_way;

  btb_way_match #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_query_match (
    .valid(q_valid), .tags(q_tags), .tag(q_tag), .match(q_match), .match_way(q_way)
  );

  btb_way_match #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_write_match (
    .valid(w_valid), .tags(w_tags), .tag(w_tag), .match(w_match), .match_way(w_way)
  );

  btb_way_match #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_inval_match (
    .valid(i_valid), .tags(i_tags), .tag(i_tag), .match(i_match), .match_way(i_way)
  );

  // Lowest invalid way first; a full set falls back to the victim pointer.
  way_t alloc_way, next_victim;

  always_comb begin
    alloc_way = victim[w_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!w_valid[w]) alloc_way = way_t'(w);
    end
    next_victim = (alloc_way == way_t'(NUM_WAYS - 1)) ? '0 : alloc_way + 1'b1;
  end

  logic same_entry;
  assign same_entry = inval_enable && (w_idx == i_idx) && (w_tag == i_tag);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        victim[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) entries[s][w] <= '0;
      end
    end else begin
      if (inval_enable && i_match) entries[i_idx][i_way].valid <= 1'b0;
      // A write to the entry being invalidated is dropped entirely.
      if (write_enable && !same_entry) begin
        if (w_match) begin
          entries[w_idx][w_way].target_pc <= write_dest_pc;
        end else begin
          entries[w_idx][alloc_way] <= '{valid: 1'b1, tag: w_tag, target_pc: write_dest_pc};
          victim[w_idx]             <= next_victim;
        end
      end
    end
  end

  assign hit       = q_match;
  assign hit_way   = q_way;
  assign target_pc = q_match ? entries[q_idx][q_way].target_pc : '0;

endmodule
